axil_master_ctrl: RTL

AXI4-Lite initiator that turns a simple single-beat command/response interface into AXI4-Lite write and read transactions toward a register_space-style slave. It is the master-side counterpart of the AXI-Lite slave port in our top-level. It lets internal sequencers and the bench program registers without hand-driving the five AXI channels. Only one transaction is outstanding at a time.

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_master_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// Shared state encoding and AXI response codes for the AXI4-Lite master controller.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA,
    RESP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // States in which the controller is waiting on the slave.
  function automatic logic is_waiting(input state_t s);
    return (s == WADDR_DATA) || (s == WRESP) || (s == RADDR) || (s == RDATA);
  endfunction

endpackage

// File: rtl/axil_master_ctrl.sv
// Single-outstanding AXI4-Lite master bridging a one-beat command/response port onto the five AXI channels.
// Defining AXIL_TIMEOUT_EN adds a slave-wait watchdog that completes a stuck transaction with SLVERR.
module axil_master_ctrl
  import axil_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] PROT           = 3'b000,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_t                    state;
  state_t                    state_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;
  logic [DATA_WIDTH/8-1:0]   wstrb_reg;
  logic                      aw_done;
  logic                      w_done;
  logic [1:0]                resp_reg;
  logic [DATA_WIDTH-1:0]     rdata_reg;
  logic                      timeout;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state_next != state)) begin
      wait_cnt <= '0;
    end else if (is_waiting(state)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = is_waiting(state) && (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Handshake outputs are pure functions of state so payloads and VALIDs never glitch mid-beat.
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? WADDR_DATA : RADDR;
      end
      WADDR_DATA: begin
        m_axi_awvalid = !aw_done && !timeout;
        m_axi_wvalid  = !w_done && !timeout;
        if (timeout) state_next = RESP;
        else if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = WRESP;
      end
      WRESP: begin
        m_axi_bready = !timeout;
        if (timeout || m_axi_bvalid) state_next = RESP;
      end
      RADDR: begin
        m_axi_arvalid = !timeout;
        if (timeout) state_next = RESP;
        else if (m_axi_arready) state_next = RDATA;
      end
      RDATA: begin
        m_axi_rready = !timeout;
        if (timeout || m_axi_rvalid) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      resp_reg  <= OKAY;
      rdata_reg <= '0;
    end else begin
      state <= state_next;
      if (timeout) begin
        resp_reg  <= SLVERR;
        rdata_reg <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              addr_reg  <= cmd_addr;
              wdata_reg <= cmd_wdata;
              wstrb_reg <= cmd_wstrb;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end
          end
          WADDR_DATA: begin
            if (m_axi_awready) aw_done <= 1'b1;
            if (m_axi_wready)  w_done  <= 1'b1;
          end
          WRESP: begin
            if (m_axi_bvalid) begin
              resp_reg  <= m_axi_bresp;
              rdata_reg <= '0;
            end
          end
          RDATA: begin
            if (m_axi_rvalid) begin
              resp_reg  <= m_axi_rresp;
              rdata_reg <= m_axi_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_axi_awaddr = addr_reg;
  assign m_axi_araddr = addr_reg;
  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;
  assign m_axi_wdata  = wdata_reg;
  assign m_axi_wstrb  = wstrb_reg;
  assign rsp_resp     = resp_reg;
  assign rsp_rdata    = rdata_reg;

endmodule
